// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, line-master FSM states and line geometry helper.
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int LINE_BYTES(input int line_words, input int data_w);
        return line_words * data_w / 8;
    endfunction

endpackage

// File: rtl/l2_axi_line_master.sv
// Cache-line AXI4 master: one INCR burst per request, fill (AR/R) or writeback (AW/W/B).
// Handshakes: a beat moves on a rising edge where valid && ready; valids are registered and never depend on ready.
module l2_axi_line_master
    import axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                         aclk,
    input  logic                         areset,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] req_wdata,

    output logic                         rsp_valid,
    output logic [LINE_WORDS*DATA_W-1:0] rsp_rdata,
    output logic                         rsp_err,

    output logic [ADDR_W-1:0]            m_axi_awaddr,
    output logic [7:0]                   m_axi_awlen,
    output logic [2:0]                   m_axi_awsize,
    output logic [1:0]                   m_axi_awburst,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,

    output logic [DATA_W-1:0]            m_axi_wdata,
    output logic [DATA_W/8-1:0]          m_axi_wstrb,
    output logic                         m_axi_wlast,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,

    input  logic [1:0]                   m_axi_bresp,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,

    output logic [ADDR_W-1:0]            m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    output logic [2:0]                   m_axi_arsize,
    output logic [1:0]                   m_axi_arburst,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,

    input  logic [DATA_W-1:0]            m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp,
    input  logic                         m_axi_rlast,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,

    output state_e                       dbg_state
);

    localparam int              CNT_W     = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]      AXLEN     = 8'(LINE_WORDS - 1);
    localparam logic [2:0]      AXSIZE    = 3'($clog2(DATA_W / 8));
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES(LINE_WORDS, DATA_W) - 1);

    state_e                       state_q;
    logic [CNT_W-1:0]             beat_q;
    logic                         err_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [LINE_WORDS*DATA_W-1:0] line_q;
    logic                         req_ready_q;
    logic                         rsp_valid_q;
    logic                         rsp_err_q;
    logic                         arvalid_q;
    logic                         awvalid_q;
    logic                         wvalid_q;
    logic                         rready_q;
    logic                         bready_q;
    logic                         last_beat;

    assign last_beat = (beat_q == LAST_BEAT);

    // One line register serves as writeback source and fill destination,
    // so rsp_rdata is meaningless after a writeback.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            line_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr & ~OFF_MASK;
                        line_q      <= req_wdata;
                        err_q       <= 1'b0;
                        beat_q      <= '0;
                        if (req_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_WADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (m_axi_rvalid) begin
                        line_q[int'(beat_q)*DATA_W +: DATA_W] <= m_axi_rdata;
                        if (m_axi_rresp != RESP_OKAY || m_axi_rlast != last_beat) begin
                            err_q <= 1'b1;
                        end
                        // Beat count, not rlast, terminates the burst.
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            state_q  <= ST_DONE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_WADDR: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (m_axi_wready) begin
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_WRESP;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                ST_WRESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rsp_err_q <= err_q;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = line_q;
    assign rsp_err       = rsp_err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = AXLEN;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_wdata   = line_q[int'(beat_q)*DATA_W +: DATA_W];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wvalid_q && last_beat;
    assign m_axi_wvalid  = wvalid_q;

    assign m_axi_bready  = bready_q;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = AXLEN;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arvalid = arvalid_q;

    assign m_axi_rready  = rready_q;

    assign dbg_state     = state_q;

endmodule

// File: doc/l2_axi_line_master.md
L2_AXI_LINE_MASTER -- requirements
Module: l2_axi_line_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI and request address width.
REQ-002 SHALL have parameter DATA_W, default 32: AXI data beat width, a power of two, minimum 8.
REQ-003 SHALL have parameter LINE_WORDS, default 8: beats per cache line, a power of two from 2 to 256.
REQ-004 SHALL use one clock; reset is asynchronous and active-high: aclk  in  1  clock (all logic on rising edge); areset  in  1  reset.
REQ-005 SHALL have cache request ports: req_valid in 1 request; req_ready out 1 accept; req_write in 1 (1 = writeback, 0 = fill); req_addr in ADDR_W line address; req_wdata in LINE_WORDS*DATA_W writeback line, word 0 in the LSBs.
REQ-006 SHALL have cache response ports: rsp_valid out 1 single-cycle completion pulse; rsp_rdata out LINE_WORDS*DATA_W fill line, word 0 in the LSBs; rsp_err out 1 error flag.
REQ-007 SHALL have AXI4 AW ports: m_axi_awaddr out ADDR_W; m_axi_awlen out 8; m_axi_awsize out 3; m_axi_awburst out 2; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-008 SHALL have AXI4 W ports: m_axi_wdata out DATA_W; m_axi_wstrb out DATA_W/8; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-009 SHALL have AXI4 B ports: m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
REQ-010 SHALL have AXI4 AR ports: m_axi_araddr out ADDR_W; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-011 SHALL have AXI4 R ports: m_axi_rdata in DATA_W; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-012 SHALL implement the FSM states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP and DONE.
REQ-013 SHALL assert req_ready only in IDLE; when req_valid && req_ready, the FSM SHALL capture req_addr (low log2(LINE_WORDS*DATA_W/8) bits forced to 0) and req_wdata, then move to WADDR if req_write else RADDR.
REQ-014 SHALL drive constant burst fields: awlen = arlen = LINE_WORDS-1; awsize = arsize = log2(DATA_W/8); awburst = arburst = 2'b01 (INCR); wstrb all ones.
REQ-015 SHALL hold awvalid/arvalid high with stable address in WADDR/RADDR until the matching ready, then move to WDATA/RDATA; no combinational path from any ready to its valid.
REQ-016 SHALL, in RDATA, hold rready = 1 and store each rdata beat into word slot beat_cnt, which increments per beat from 0.
REQ-017 SHALL, in WDATA, hold wvalid = 1 with wdata = captured word beat_cnt and wlast = (beat_cnt == LINE_WORDS-1); it SHALL advance only on wready and move to WRESP after the last beat.
REQ-018 SHALL, in WRESP, hold bready = 1 and move to DONE on bvalid.
REQ-019 SHALL leave RDATA for DONE on the beat where beat_cnt == LINE_WORDS-1, regardless of rlast.
REQ-020 SHALL set a sticky error flag, cleared on request accept, on any of: rresp != 2'b00; bresp != 2'b00; rlast low on the final beat; rlast high on an earlier beat.
REQ-021 SHALL, in DONE, pulse rsp_valid for one cycle with rsp_err = the error flag and then return to IDLE. rsp_rdata SHALL stay valid until the next accept and is undefined after a write.
REQ-022 Latency with zero-wait slave SHALL be: read accept to rsp_valid = LINE_WORDS+3 cycles; write accept to rsp_valid = LINE_WORDS+4 cycles.
REQ-023 SHALL keep only one transaction outstanding; AR and AW never active together.

Reset
REQ-024 On areset, the FSM SHALL enter IDLE asynchronously, including mid-burst.
REQ-025 On areset, the following SHALL be 0: every valid/ready output, req_ready (goes to 1 on the first clock after release), rsp_valid, rsp_err, beat_cnt, the error flag, rsp_rdata, and the captured line.
REQ-026 An interrupted transaction SHALL produce no rsp_valid.

Structure
REQ-027 The FSM state enum, AXI burst/resp encodings (INCR, OKAY, SLVERR) and a LINE_BYTES helper function SHALL live in axi_pkg.
REQ-028 The block SHALL be a single module; the beat counter and line register are inline, with no sub-modules.

Verification
REQ-029 Fill, req_addr 0x0000_1234, zero-wait slave returning rdata = beat index -> araddr 0x1220, arlen 7, arsize 2, arburst 1; rsp_rdata words 0..7 = 0..7; rsp_err 0; rsp_valid 11 cycles after accept.
REQ-030 Writeback of line 0x0000_4000, data word i = 0xA0+i, wready low on every other cycle -> awaddr 0x4000; 8 beats in order; wlast only on the 8th; bresp OKAY -> rsp_err 0.
REQ-031 Fill where beat 3 has rresp = 2'b10 -> all 8 beats still consumed; rsp_err 1.
REQ-032 Fill where rlast is asserted on beat 5 -> rsp_err 1; FSM still consumes 8 beats and returns to IDLE.
REQ-033 areset asserted after beat 4 of a fill -> rready/arvalid low immediately; no rsp_valid; a new request is accepted normally after release.
REQ-034 Back-to-back requests with req_valid held high -> second accept occurs exactly one cycle after the first rsp_valid pulse.
